// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - sequential float32 argmax over a captured score vector
// Snapshot on start, scan one element per cycle, publish index/value on done.
module fc_argmax #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 32,
  parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] scores_in,
  output logic                              busy,
  output logic                              done,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             class_score,
  output logic                              all_nan
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [DATA_WIDTH-1:0] NEG_INF  = 32'hFF80_0000;
  localparam logic [DATA_WIDTH-1:0] QNAN     = 32'h7FC0_0000;

  state_t                            state, state_next;
  logic [DATA_WIDTH*NUM_CLASSES-1:0] snapshot;
  logic [IDX_WIDTH-1:0]              cnt;
  logic [IDX_WIDTH-1:0]              best_idx;
  logic [DATA_WIDTH-1:0]             best_val;
  logic                              found;
  logic [DATA_WIDTH-1:0]             elem;
  logic                              elem_nan;
  logic                              take;

  // Sign-magnitude ordering; +0/-0 are equal, inf is ordinary, NaN excluded by caller.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic a_zero, b_zero;
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if (a_zero && b_zero)       fp_gt = 1'b0;
    else if (!a[31] && b[31])   fp_gt = 1'b1;
    else if (a[31] && !b[31])   fp_gt = 1'b0;
    else if (!a[31])            fp_gt = (a[30:0] > b[30:0]);
    else                        fp_gt = (a[30:0] < b[30:0]);
  endfunction

  assign elem     = snapshot[DATA_WIDTH*cnt +: DATA_WIDTH];
  assign elem_nan = (elem[30:23] == 8'hFF) && (elem[22:0] != 23'd0);
  assign take     = !elem_nan && (!found || fp_gt(elem, best_val));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (cnt == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot content is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) snapshot <= scores_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      found       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      all_nan     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            best_idx <= '0;
            best_val <= NEG_INF;
            found    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (take) begin
            best_idx <= cnt;
            best_val <= elem;
          end
          if (!elem_nan) found <= 1'b1;
          if (cnt != LAST_IDX) cnt <= cnt + 1'b1;
        end
        DONE: begin
          class_idx   <= best_idx;
          class_score <= found ? best_val : QNAN;
          all_nan     <= !found;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// tb/tb_fc_argmax.sv - scoreboard bench for fc_argmax
module tb_fc_argmax;

  localparam int N  = 32;
  localparam int IW = $clog2(N);
  localparam int VW = 32 * N;

  typedef logic [VW-1:0] vec_t;
  typedef struct {
    logic [IW-1:0] idx;
    logic [31:0]   score;
    logic          nan;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  vec_t            scores_in = '0;
  logic            busy;
  logic            done;
  logic [IW-1:0]   class_idx;
  logic [31:0]     class_score;
  logic            all_nan;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fc_argmax #(.DATA_WIDTH(32), .NUM_CLASSES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .scores_in(scores_in),
    .busy(busy), .done(done), .class_idx(class_idx),
    .class_score(class_score), .all_nan(all_nan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] int_to_f32(input int i);
    int          e;
    logic [31:0] m;
    if (i == 0) return 32'd0;
    e = 0;
    while ((i >> (e + 1)) != 0) e++;
    m = 32'(i) << (23 - e);
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  function automatic vec_t fill(input logic [31:0] val);
    vec_t v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = val;
    return v;
  endfunction

  function automatic vec_t ramp();
    vec_t v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = int_to_f32(i);
    return v;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("class_idx", 32'(class_idx), 32'(e.idx));
        chk("class_score", class_score, e.score);
        chk("all_nan", 32'(all_nan), 32'(e.nan));
      end
    end
  end

  task automatic run_vec(input vec_t v, input logic [IW-1:0] ei, input logic [31:0] es,
                         input logic en, input bit second_start, input vec_t v2);
    int lat;
    exp_q.push_back('{idx: ei, score: es, nan: en});
    @(negedge clk);
    scores_in = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scores_in = fill(32'h4F00_0000);
    chk("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (second_start && lat == 9) begin
        start = 1'b1;
        scores_in = v2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_latency", 32'(lat), 32'(N + 1));
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    vec_t v, tie_v, ramp17;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_idx", 32'(class_idx), 32'd0);
    chk("reset_score", class_score, 32'd0);
    chk("reset_all_nan", 32'(all_nan), 32'd0);

    ramp17 = ramp();
    ramp17[32*17 +: 32] = 32'h42C8_0000;
    run_vec(ramp17, 5'd17, 32'h42C8_0000, 1'b0, 1'b0, '0);

    tie_v = fill(32'hBF80_0000);
    tie_v[32*5 +: 32] = 32'hBF00_0000;
    tie_v[32*9 +: 32] = 32'hBF00_0000;
    run_vec(tie_v, 5'd5, 32'hBF00_0000, 1'b0, 1'b0, '0);

    v = fill(32'hC000_0000);
    v[32*0 +: 32] = 32'h8000_0000;
    v[32*3 +: 32] = 32'h0000_0000;
    run_vec(v, 5'd0, 32'h8000_0000, 1'b0, 1'b0, '0);

    v[32*4 +: 32] = 32'h7FC0_0001;
    v[32*6 +: 32] = 32'h7F80_0000;
    run_vec(v, 5'd6, 32'h7F80_0000, 1'b0, 1'b0, '0);

    run_vec(fill(32'h7FC0_0000), 5'd0, 32'h7FC0_0000, 1'b1, 1'b0, '0);
    run_vec(ramp(), 5'd31, 32'h41F8_0000, 1'b0, 1'b0, '0);

    v = fill(32'hFF80_0000);
    v[32*2 +: 32] = 32'h0000_0001;
    v[32*7 +: 32] = 32'h0000_0002;
    run_vec(v, 5'd7, 32'h0000_0002, 1'b0, 1'b0, '0);

    run_vec(fill(32'hFF80_0000), 5'd0, 32'hFF80_0000, 1'b0, 1'b0, '0);

    run_vec(ramp17, 5'd17, 32'h42C8_0000, 1'b0, 1'b1, tie_v);

    // Second start mid-scan, then reset before completion: no result expected.
    @(negedge clk);
    scores_in = ramp17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    scores_in = tie_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_idx", 32'(class_idx), 32'd0);
    chk("abort_score", class_score, 32'd0);
    chk("abort_all_nan", 32'(all_nan), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_vec(tie_v, 5'd5, 32'hBF00_0000, 1'b0, 1'b0, '0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
